plot_arbiter: RTL
=================

Name: plot_arbiter

Overview:
- Shares the single vga_adapter pixel-write port (x, y, colour, plot) between up to 4 drawing engines, e.g. the screen-fill datapath/statemachine pair and a later line or sprite engine.
- Each engine offers pixels through a valid/ready handshake.
- Arbitration is round-robin at burst granularity. A granted engine keeps the port until it flags its last pixel, or until it idles past a timeout.
- All outputs to the adapter are registered.

Parameters:
- NUM_REQ, 2: number of requesters, legal range 2..4.
- LOCK_TIMEOUT, 255: consecutive idle cycles (granted requester's valid low) before the lock is forcibly released; 0 disables the timeout.
- TO_W, 8: width of the timeout counter; must hold LOCK_TIMEOUT.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- resetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester pixel valid
- req_last  in  NUM_REQ  per-requester last pixel of burst, qualified by valid
- req_x  in  NUM_REQ*8  packed x coordinates, requester i at [8i+7:8i]
- req_y  in  NUM_REQ*7  packed y coordinates
- req_colour  in  NUM_REQ*3  packed colours
- req_ready  out  NUM_REQ  per-requester ready
- grant  out  NUM_REQ  one-hot current owner, all zero when idle
- busy  out  1  high while in LOCKED
- x  out  8  to vga_adapter
- y  out  7  to vga_adapter
- colour  out  3  to vga_adapter
- plot  out  1  single-cycle write strobe to vga_adapter

Behaviour:
- Reset values (async, resetn low): state IDLE, grant 0, req_ready 0, busy 0, plot 0, x 0, y 0, colour 0, priority pointer 0, timeout counter 0.
- State IDLE:
  - If any req_valid is high, select the first valid index searching from ptr upward with wrap-around (ptr..NUM_REQ-1, then 0..ptr-1).
  - Register that index as grant and go to LOCKED.
  - If no req_valid is high, stay in IDLE.
  - req_ready is all zero in IDLE.
- State LOCKED:
  - req_ready[g] = 1 for the granted index g only; this is a combinational decode of registered grant.
  - A pixel is accepted when req_valid[g] & req_ready[g].
  - On accept, the next cycle has plot = 1 and x/y/colour equal to the accepted slice. Without an accept, plot = 0 and x/y/colour hold their last value.
  - Accept with req_last[g] = 1: go to IDLE, clear grant, set ptr = (g+1) mod NUM_REQ.
- Latency and throughput:
  - req_valid rising in IDLE at cycle t gives grant and ready at t+1; the first accept is at t+1 and its plot at t+2.
  - 1 pixel/cycle within a burst.
  - Exactly one IDLE bubble cycle between bursts.
- Timeout:
  - In LOCKED with LOCK_TIMEOUT > 0, the counter increments on each cycle where req_valid[g] = 0 and clears on any cycle where it is 1.
  - When the counter reaches LOCK_TIMEOUT, go to IDLE with no plot and advance ptr as for a last-pixel accept.
  - The counter clears on entry to LOCKED.
- Non-granted requesters: their req_valid is ignored while LOCKED; they must hold their request until granted.
- Simultaneous events:
  - Last-pixel accept and timeout cannot coincide, since an accept implies valid is high.
  - A requester may re-request in the cycle after its last accept. It is granted only if no other requester is valid, because ptr has already moved past it.
- Reset mid-burst: all state clears immediately and any pending plot is suppressed. Requesters see req_ready drop asynchronously.
- Widths: x/y/colour are passed unmodified; no arithmetic except the ptr increment mod NUM_REQ and the timeout counter, which saturates at LOCK_TIMEOUT.

Optional Feature:
- Macro: PLOT_ARBITER_CLIP_EN.
- Defined:
  - An accepted pixel with x >= 160 or y >= 120 is still accepted and consumed, but produces no plot; the output registers keep their previous values.
  - Adds output clip_drop (out, 1): a single-cycle pulse aligned with the suppressed plot slot.
- Undefined:
  - No clip_drop port.
  - All accepted pixels are plotted verbatim; out-of-range handling is left to vga_adapter.

Decomposition:
- Shared package vga_pkg holds:
  - X_W = 8, Y_W = 7, COL_W = 3, SCREEN_WIDTH = 160, SCREEN_HEIGHT = 120
  - colour constants BLACK/BLUE/GREEN/YELLOW/RED/WHITE
  - state enum {IDLE, LOCKED}
- One sub-module, rr_pick: combinational round-robin selector with inputs valid vector and ptr, outputs index and any_valid. Everything else stays in plot_arbiter.

Test Plan:
- Reset: resetn low mid-burst while plot = 1 in the next slot -> plot, grant, req_ready, busy all 0 immediately; after release the state is IDLE and ptr = 0.
- Single burst: requester 0 sends 3 pixels (10,5,RED), (11,5,RED), (12,5,RED) with last on the third -> grant = 01 at t+1; plot high at t+2..t+4 with matching x/y/colour; IDLE at t+4; ptr = 1.
- Contention: requesters 0 and 1 both valid from reset, each sending a 2-pixel burst -> order is req0 then req1, one bubble between them; req1's ready stays 0 during req0's burst; ptr ends at 0.
- Round-robin fairness: both requesters continuously re-request 1-pixel bursts for 20 bursts -> grants alternate strictly 0,1,0,1; counts are 10/10.
- Timeout: LOCK_TIMEOUT = 4; requester 1 is granted, sends 1 non-last pixel, then drops valid -> after 4 idle cycles the state is IDLE, grant = 0, no extra plot, and requester 0 wins next.
- Clip (PLOT_ARBITER_CLIP_EN): pixels (159,119), (160,0), (0,120) -> first plots; second and third give clip_drop pulses, plot = 0, and are still consumed (ready high, accepted).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA drawing definitions: coordinate/colour widths, visible screen
// size, the 3-bit colour palette, and the arbiter state encoding.
// No ports; imported with `import vga_pkg::*;`.
package vga_pkg;

  localparam int X_W           = 8;
  localparam int Y_W           = 7;
  localparam int COL_W         = 3;
  localparam int SCREEN_WIDTH  = 160;
  localparam int SCREEN_HEIGHT = 120;

  localparam logic [COL_W-1:0] BLACK  = 3'b000;
  localparam logic [COL_W-1:0] BLUE   = 3'b001;
  localparam logic [COL_W-1:0] GREEN  = 3'b010;
  localparam logic [COL_W-1:0] YELLOW = 3'b110;
  localparam logic [COL_W-1:0] RED    = 3'b100;
  localparam logic [COL_W-1:0] WHITE  = 3'b111;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // True when the pixel lies inside the visible 160x120 frame.
  function automatic logic on_screen(input logic [X_W-1:0] px,
                                     input logic [Y_W-1:0] py);
    return (px < X_W'(SCREEN_WIDTH)) && (py < Y_W'(SCREEN_HEIGHT));
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   valid     in  N      request vector
//   ptr       in  IDX_W  highest-priority index this round (must be < N)
//   idx       out IDX_W  first valid index at or after ptr, wrapping
//   any_valid out 1      at least one request is valid
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any_valid
);

  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    idx       = '0;
    found     = 1'b0;
    cand      = '0;
    any_valid = |valid;
    for (int k = 0; k < N; k++) begin
      // Candidate = (ptr + k) mod N, kept one bit wider to catch the wrap.
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      if (!found && valid[cand[IDX_W-1:0]]) begin
        idx   = cand[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// Shares the vga_adapter pixel-write port between NUM_REQ drawing engines.
// Round-robin at burst granularity: the granted engine owns the port until
// it sends a last pixel or stays idle for LOCK_TIMEOUT cycles.
// Optional build macro: PLOT_ARBITER_CLIP_EN (drop off-screen pixels, adds
// the clip_drop output).
// Ports:
//   clk, resetn              clock, async active-low reset
//   req_valid/req_last       per-engine handshake and end-of-burst flag
//   req_x/req_y/req_colour   packed per-engine pixel, engine i at slice i
//   req_ready                per-engine ready (decode of registered grant)
//   grant                    one-hot owner, zero when idle
//   busy                     high while a burst is locked
//   x/y/colour/plot          registered pixel write to vga_adapter
//   clip_drop                (clip build only) pulse in a suppressed slot
//
// state  | meaning
// IDLE   | no owner; pick next engine round-robin from ptr
// LOCKED | grant holds the owner; accept its pixels at one per cycle
module plot_arbiter
  import vga_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 255,
  parameter int TO_W         = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*X_W-1:0]   req_x,
  input  logic [NUM_REQ*Y_W-1:0]   req_y,
  input  logic [NUM_REQ*COL_W-1:0] req_colour,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [X_W-1:0]           x,
  output logic [Y_W-1:0]           y,
  output logic [COL_W-1:0]         colour,
`ifdef PLOT_ARBITER_CLIP_EN
  output logic                     clip_drop,
`endif
  output logic                     plot
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               plot_q, plot_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [COL_W-1:0]   colour_q, colour_d;
`ifdef PLOT_ARBITER_CLIP_EN
  logic               clip_drop_q, clip_drop_d;
`endif

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [IDX_W-1:0]   ptr_inc;
  logic               sel_valid, sel_last;
  logic [X_W-1:0]     sel_x;
  logic [Y_W-1:0]     sel_y;
  logic [COL_W-1:0]   sel_col;
  logic               accept;
  logic               to_hit;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .valid     (req_valid),
    .ptr       (ptr_q),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  // Owner's handshake and pixel, selected by the registered grant index.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    sel_col   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_x     = req_x[i*X_W +: X_W];
        sel_y     = req_y[i*Y_W +: Y_W];
        sel_col   = req_colour[i*COL_W +: COL_W];
      end
    end
  end

  assign ptr_inc = (gidx_q == IDX_W'(NUM_REQ-1)) ? '0 : gidx_q + 1'b1;
  assign accept  = (state_q == LOCKED) && sel_valid;

  // Release fires on the idle cycle that would bring the count to
  // LOCK_TIMEOUT, so exactly LOCK_TIMEOUT idle cycles are spent locked.
  assign to_hit  = (LOCK_TIMEOUT != 0) && (state_q == LOCKED) && !sel_valid
                   && (to_cnt_q == TO_W'(LOCK_TIMEOUT-1));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      IDLE: begin
        grant_d  = '0;
        to_cnt_d = '0;
        if (pick_any) begin
          state_d = LOCKED;
          gidx_d  = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
        end
      end
      LOCKED: begin
        if ((accept && sel_last) || to_hit) begin
          state_d  = IDLE;
          grant_d  = '0;
          ptr_d    = ptr_inc;
          to_cnt_d = '0;
        end else if (sel_valid) begin
          to_cnt_d = '0;
        end else if (LOCK_TIMEOUT != 0) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Output pixel registers: load on accept, otherwise hold with plot low.
  always_comb begin
    plot_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
`ifdef PLOT_ARBITER_CLIP_EN
    clip_drop_d = 1'b0;
    if (accept) begin
      if (on_screen(sel_x, sel_y)) begin
        plot_d   = 1'b1;
        x_d      = sel_x;
        y_d      = sel_y;
        colour_d = sel_col;
      end else begin
        // Consumed from the engine but never written to the frame.
        clip_drop_d = 1'b1;
      end
    end
`else
    if (accept) begin
      plot_d   = 1'b1;
      x_d      = sel_x;
      y_d      = sel_y;
      colour_d = sel_col;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      ptr_q    <= '0;
      to_cnt_q <= '0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= BLACK;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      to_cnt_q <= to_cnt_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
    end
  end

`ifdef PLOT_ARBITER_CLIP_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clip_drop_q <= 1'b0;
    end else begin
      clip_drop_q <= clip_drop_d;
    end
  end

  assign clip_drop = clip_drop_q;
`endif

  // grant_q is zero outside LOCKED, so ready is a straight copy and drops
  // asynchronously with reset.
  assign req_ready = grant_q;
  assign grant     = grant_q;
  assign busy      = (state_q == LOCKED);
  assign plot      = plot_q;
  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;

endmodule
